// File: rtl/comporta_controle.sv
// Floodgate controller: drives the gate one step per interval toward a selectable
// opening, closes it when the request drops, and fast-closes on emergency.
module comporta_controle #(
  parameter int POS_W    = 4,
  parameter int POS_MAX  = 15,
  parameter int INTERVAL = 50,
  parameter int INT_W    = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             abrirComporta,
  input  logic [POS_W-1:0] nivelAlvo,
  input  logic             emergencia,
  output logic [POS_W-1:0] posicao,
  output logic             passo,
  output logic             sentido,
  output logic             movendo,
  output logic             fechada,
  output logic             noAlvo,
  output logic [3:0]       dbEstado
);

  typedef enum logic [2:0] {
    INICIAL          = 3'd0,
    PREPARA          = 3'd1,
    MUDA_POSICAO     = 3'd2,
    ESPERA_INTERVALO = 3'd3,
    ESPERA_FECHAR    = 3'd4,
    EMERGENCIA       = 3'd5
  } estado_t;

  localparam logic [POS_W-1:0] POS_LIM = POS_W'(POS_MAX);
  localparam logic [INT_W-1:0] CNT_FIM = INT_W'(INTERVAL - 1);

  estado_t          estado, proxEstado;
  logic [INT_W-1:0] contador, proxContador;
  logic [POS_W-1:0] proxPosicao, alvo;
  logic             sobe, desce;

  // Goal: emergency forces closed, otherwise the clamped request level.
  always_comb begin
    alvo = '0;
    if (!emergencia && abrirComporta)
      alvo = (nivelAlvo > POS_LIM) ? POS_LIM : nivelAlvo;
  end

  assign sobe  = (alvo > posicao) && (posicao != POS_LIM);
  assign desce = (alvo < posicao) && (posicao != '0);

  always_comb begin
    proxEstado   = estado;
    proxPosicao  = posicao;
    proxContador = contador;
    passo        = 1'b0;
    sentido      = 1'b0;
    case (estado)
      INICIAL: begin
        // Compare against posicao so a recovered illegal state still homes out.
        if (alvo != posicao) proxEstado = PREPARA;
      end
      PREPARA: begin
        proxContador = '0;
        proxEstado   = MUDA_POSICAO;
      end
      MUDA_POSICAO: begin
        if (sobe) begin
          proxPosicao = posicao + 1'b1;
          passo       = 1'b1;
          sentido     = 1'b1;
        end else if (desce) begin
          proxPosicao = posicao - 1'b1;
          passo       = 1'b1;
        end
        proxContador = '0;
        proxEstado   = ESPERA_INTERVALO;
      end
      ESPERA_INTERVALO: begin
        if (emergencia) begin
          proxEstado = EMERGENCIA;
        end else if (contador == CNT_FIM) begin
          proxContador = '0;
          if (posicao != alvo)    proxEstado = MUDA_POSICAO;
          else if (posicao == '0) proxEstado = INICIAL;
          else                    proxEstado = ESPERA_FECHAR;
        end else begin
          proxContador = contador + 1'b1;
        end
      end
      ESPERA_FECHAR: begin
        if (emergencia)           proxEstado = EMERGENCIA;
        else if (alvo != posicao) proxEstado = MUDA_POSICAO;
      end
      EMERGENCIA: begin
        if (posicao != '0) begin
          proxPosicao = posicao - 1'b1;
          passo       = 1'b1;
        end else begin
          proxEstado = INICIAL;
        end
      end
      default: proxEstado = INICIAL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado   <= INICIAL;
      posicao  <= '0;
      contador <= '0;
    end else begin
      estado   <= proxEstado;
      posicao  <= proxPosicao;
      contador <= proxContador;
    end
  end

  assign movendo = (estado == PREPARA) || (estado == MUDA_POSICAO) ||
                   (estado == ESPERA_INTERVALO) || (estado == EMERGENCIA);
  assign fechada = (estado == INICIAL);
  assign noAlvo  = ((estado == INICIAL) || (estado == ESPERA_FECHAR)) && (posicao == alvo);

  always_comb begin
    case (estado)
      INICIAL, PREPARA, MUDA_POSICAO, ESPERA_INTERVALO, ESPERA_FECHAR, EMERGENCIA:
        dbEstado = {1'b0, estado};
      default: dbEstado = 4'b1111;
    endcase
  end

endmodule
